// File: rtl/pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl
//
// Reset and clock-enable controller placed right after the iCE40 PLL / clock
// divider. The processor is held in reset until the synchronized PLL lock has
// been stable for LOCK_STABLE_CYCLES, then for a further RESET_HOLD_CYCLES.
// After that it releases a registered, synchronous-deassert system reset. While
// running it emits a one-cycle clock-enable strobe every CE_DIV cycles. Loss of
// lock or a software reset request puts the core back into reset cleanly.
//
// Ports:
//   clock          in  system clock (divided PLL output), rising edge
//   reset_n        in  asynchronous active-low reset
//   pll_lock       in  PLL LOCK, asynchronous to clock
//   soft_reset_req in  single-cycle request to re-reset the core (RUN only)
//   lock_lost_clr  in  synchronous clear of the sticky lock_lost flag
//   sys_reset_n    out active-low processor reset, high only in RUN
//   ready          out high only in RUN
//   lock_lost      out sticky flag, set when lock drops while in RUN
//   clk_en         out one-cycle strobe every CE_DIV cycles while in RUN
// -----------------------------------------------------------------------------
module pll_reset_ctrl #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned CE_DIV             = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pll_lock,
  input  logic soft_reset_req,
  input  logic lock_lost_clr,
  output logic sys_reset_n,
  output logic ready,
  output logic lock_lost,
  output logic clk_en
);

  // The shared counter only ever has to reach max(N, M) - 1.
  localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                    LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABILIZE = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               clk_en_q, clk_en_d;
  logic               lock_lost_q, lock_lost_d;
  logic               sys_reset_n_q;
  logic               ready_q;
  logic               lost_set_s;
  logic               run_stay_s;

  // Only the last synchronizer stage is ever looked at by the FSM.
  assign lock_s = sync_q[SYNC_STAGES-1];

  // Multi-flop synchronizer for the asynchronous PLL lock input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  // Next-state and shared counter logic for the reset sequencing FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lost_set_s = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_STABILIZE: begin
        // Any drop discards the accumulated count entirely.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STAB_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          state_d = ST_STABILIZE;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        // Lock loss outranks a simultaneous soft reset request.
        if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          cnt_d      = '0;
          lost_set_s = 1'b1;
        end else if (soft_reset_req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Clock-enable divider; only advances while staying in RUN so every entry
  // into RUN restarts the strobe phase and leaving RUN kills the strobe.
  always_comb begin
    run_stay_s = (state_q == ST_RUN) && (state_d == ST_RUN);
    div_d      = '0;
    clk_en_d   = 1'b0;
    if (run_stay_s) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        clk_en_d = 1'b1;
      end else begin
        div_d    = div_q + DIV_ONE;
        clk_en_d = 1'b0;
      end
    end else begin
      div_d    = '0;
      clk_en_d = 1'b0;
    end
  end

  // Sticky lock-lost flag; a set on the same edge as a clear takes priority.
  always_comb begin
    if (lost_set_s) begin
      lock_lost_d = 1'b1;
    end else if (lock_lost_clr) begin
      lock_lost_d = 1'b0;
    end else begin
      lock_lost_d = lock_lost_q;
    end
  end

  // FSM state, counters and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_WAIT_LOCK;
      cnt_q         <= '0;
      div_q         <= '0;
      clk_en_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      clk_en_q      <= clk_en_d;
      lock_lost_q   <= lock_lost_d;
      // Reset/ready track the state being entered on this same edge.
      sys_reset_n_q <= (state_d == ST_RUN);
      ready_q       <= (state_d == ST_RUN);
    end
  end

  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign clk_en      = clk_en_q;

endmodule
